// File: rtl/dut_chk_pkg.sv
// Shared types for the stream checker: error codes, FIFO entry layout, saturating increment.
package dut_chk_pkg;

  localparam int unsigned CHK_DATA_W = 8;
  localparam int unsigned CHK_TS_W   = 8;

  typedef enum logic [2:0] {
    ERR_NONE,
    ERR_MISMATCH,
    ERR_TIMING,
    ERR_UNDER,
    ERR_OVER
  } err_e;

  // One expected byte plus the timestamp of the cycle it was accepted
  typedef struct packed {
    logic [CHK_DATA_W-1:0] data;
    logic [CHK_TS_W-1:0]   ts;
  } exp_entry_t;

  // Increment that sticks at max_val instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/dut_stream_checker_if.sv
// Monitor bundle between the checked DUT's rx/tx stream and the stream checker.
interface dut_stream_checker_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned LVL_W  = 5
);
  logic [DATA_W-1:0] rxd;
  logic              rx_dv;
  logic [DATA_W-1:0] txd;
  logic              tx_en;
  logic              clear;
  logic              err_mismatch;
  logic              err_timing;
  logic              err_underflow;
  logic              err_overflow;
  logic              err_sticky;
  logic [CNT_W-1:0]  match_cnt;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic [LVL_W-1:0]  level;

  modport master (
    output rxd, rx_dv, txd, tx_en, clear,
    input  err_mismatch, err_timing, err_underflow, err_overflow, err_sticky,
    input  match_cnt, mismatch_cnt, level
  );

  modport slave (
    input  rxd, rx_dv, txd, tx_en, clear,
    output err_mismatch, err_timing, err_underflow, err_overflow, err_sticky,
    output match_cnt, mismatch_cnt, level
  );
endinterface

// File: rtl/dut_chk_fifo.sv
// Synchronous FIFO of expected entries; accepts push+pop in the same cycle even when full.
module dut_chk_fifo
  import dut_chk_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  exp_entry_t                 entry_i,
  output exp_entry_t                 head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_q, wr_d;
  logic [AW:0] rd_q, rd_d;
  logic        do_push_c;
  logic        do_pop_c;
  exp_entry_t  mem_q [DEPTH];

  // Pointer next-state; a pop frees the slot a same-cycle push needs when full
  always_comb begin
    empty_o   = (wr_q == rd_q);
    full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop_c  = pop_i && !empty_o;
    do_push_c = push_i && (!full_o || do_pop_c);
    wr_d      = do_push_c ? wr_q + (AW+1)'(1) : wr_q;
    rd_d      = do_pop_c  ? rd_q + (AW+1)'(1) : rd_q;
    level_o   = wr_q - rd_q;
    head_o    = mem_q[rd_q[AW-1:0]];
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // Storage array, no reset needed: contents are only read behind valid pointers
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_q[AW-1:0]] <= entry_i;
  end

endmodule

// File: rtl/dut_stream_checker.sv
// Scoreboard that checks every accepted rx byte reappears on tx, in order, within latency limits.
module dut_stream_checker
  import dut_chk_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FIXED_LAT = 1,
  parameter int unsigned MAX_LAT   = 32,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TS_W      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  dut_stream_checker_if.slave  bus
);

  localparam int unsigned    LVL_W     = $clog2(DEPTH) + 1;
  localparam logic [TS_W-1:0] FIX_AGE   = TS_W'(FIXED_LAT);
  localparam logic [TS_W-1:0] MAX_AGE   = TS_W'(MAX_LAT);
  localparam logic [TS_W-1:0] LIMIT_AGE = TS_W'(MAX_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [TS_W-1:0]  age_c;
  exp_entry_t       head_c, push_entry_c;
  logic             fifo_full_c, fifo_empty_c, fifo_pop_c;
  logic [LVL_W-1:0] fifo_level_c;
  logic             pop_tx_c, timeout_c, late_c, match_ev_c, miss_ev_c;

  logic             err_mismatch_q, err_mismatch_d;
  logic             err_timing_q, err_timing_d;
  logic             err_underflow_q, err_underflow_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;

  dut_chk_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bus.rx_dv),
    .pop_i   (fifo_pop_c),
    .entry_i (push_entry_c),
    .head_o  (head_c),
    .full_o  (fifo_full_c),
    .empty_o (fifo_empty_c),
    .level_o (fifo_level_c)
  );

  // Compare, latency and timeout evaluation plus error/counter next-state
  always_comb begin
    ts_d              = ts_q + TS_W'(1);
    push_entry_c.data = CHK_DATA_W'(bus.rxd);
    push_entry_c.ts   = CHK_TS_W'(ts_q);
    age_c             = ts_q - TS_W'(head_c.ts);
    pop_tx_c          = bus.tx_en && !fifo_empty_c;
    timeout_c         = !fifo_empty_c && !bus.tx_en && (age_c == LIMIT_AGE);
    late_c            = (FIXED_LAT != 0) ? (age_c != FIX_AGE) : (age_c > MAX_AGE);
    fifo_pop_c        = pop_tx_c || timeout_c;

    err_underflow_d   = bus.tx_en && fifo_empty_c;
    err_mismatch_d    = pop_tx_c && (DATA_W'(head_c.data) != bus.txd);
    err_timing_d      = (pop_tx_c && late_c) || timeout_c;
    err_overflow_d    = bus.rx_dv && fifo_full_c && !fifo_pop_c;

    match_ev_c        = pop_tx_c && !err_mismatch_d && !late_c;
    miss_ev_c         = err_mismatch_d || err_timing_d || err_underflow_d;

    match_cnt_d       = match_cnt_q;
    mismatch_cnt_d    = mismatch_cnt_q;
    err_sticky_d      = err_sticky_q;
    if (bus.clear) begin
      match_cnt_d    = '0;
      mismatch_cnt_d = '0;
      err_sticky_d   = 1'b0;
    end else begin
      if (match_ev_c) match_cnt_d    = CNT_W'(sat_inc(32'(match_cnt_q), 32'(CNT_MAX)));
      if (miss_ev_c)  mismatch_cnt_d = CNT_W'(sat_inc(32'(mismatch_cnt_q), 32'(CNT_MAX)));
      if (miss_ev_c || err_overflow_d) err_sticky_d = 1'b1;
    end
  end

  // Timestamp, error pulse and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q            <= '0;
      err_mismatch_q  <= 1'b0;
      err_timing_q    <= 1'b0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
      err_sticky_q    <= 1'b0;
      match_cnt_q     <= '0;
      mismatch_cnt_q  <= '0;
    end else begin
      ts_q            <= ts_d;
      err_mismatch_q  <= err_mismatch_d;
      err_timing_q    <= err_timing_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
      err_sticky_q    <= err_sticky_d;
      match_cnt_q     <= match_cnt_d;
      mismatch_cnt_q  <= mismatch_cnt_d;
    end
  end

  assign bus.err_mismatch  = err_mismatch_q;
  assign bus.err_timing    = err_timing_q;
  assign bus.err_underflow = err_underflow_q;
  assign bus.err_overflow  = err_overflow_q;
  assign bus.err_sticky    = err_sticky_q;
  assign bus.match_cnt     = match_cnt_q;
  assign bus.mismatch_cnt  = mismatch_cnt_q;
  assign bus.level         = fifo_level_c;

`ifndef SYNTHESIS
  // Each detected stream error must surface on its named pulse one cycle later
  a_mismatch: assert property (@(posedge clk) disable iff (rst) err_mismatch_d |=> err_mismatch_q)
    else $error("stream checker: data mismatch event not reported");
  a_timing: assert property (@(posedge clk) disable iff (rst) err_timing_d |=> err_timing_q)
    else $error("stream checker: latency violation event not reported");
  a_underflow: assert property (@(posedge clk) disable iff (rst) err_underflow_d |=> err_underflow_q)
    else $error("stream checker: tx with no expected entry not reported");
  a_overflow: assert property (@(posedge clk) disable iff (rst) err_overflow_d |=> err_overflow_q)
    else $error("stream checker: dropped rx on full FIFO not reported");
`endif

endmodule

// File: tb/tb_dut_stream_checker.sv
// Directed bench: one fixed-latency and one bounded-latency checker driven by the same stream.
module tb_dut_stream_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rxd, txd;
  logic       rx_dv, tx_en, clear;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  dut_stream_checker_if #(.DATA_W(8), .CNT_W(2), .LVL_W(3)) if_f ();
  dut_stream_checker_if #(.DATA_W(8), .CNT_W(2), .LVL_W(3)) if_b ();

  assign if_f.rxd = rxd;  assign if_f.rx_dv = rx_dv;  assign if_f.txd = txd;
  assign if_f.tx_en = tx_en;  assign if_f.clear = clear;
  assign if_b.rxd = rxd;  assign if_b.rx_dv = rx_dv;  assign if_b.txd = txd;
  assign if_b.tx_en = tx_en;  assign if_b.clear = clear;

  dut_stream_checker #(.DATA_W(8), .DEPTH(4), .FIXED_LAT(1), .MAX_LAT(4), .CNT_W(2), .TS_W(8))
    u_dut_f (.clk(clk), .rst(rst), .bus(if_f.slave));
  dut_stream_checker #(.DATA_W(8), .DEPTH(4), .FIXED_LAT(0), .MAX_LAT(4), .CNT_W(2), .TS_W(8))
    u_dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rx_dv = 1'b0; tx_en = 1'b0; clear = 1'b0; rxd = 8'h00; txd = 8'h00;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({if_f.err_mismatch, if_f.err_timing, if_f.err_underflow, if_f.err_overflow, if_f.err_sticky} !== 5'b0) begin
      errors++; $display("FAIL reset_err_f got %b exp 00000",
        {if_f.err_mismatch, if_f.err_timing, if_f.err_underflow, if_f.err_overflow, if_f.err_sticky});
    end
    checks++;
    if ({if_f.match_cnt, if_f.mismatch_cnt, if_f.level} !== 7'b0) begin
      errors++; $display("FAIL reset_cnt_f got %b exp 0000000", {if_f.match_cnt, if_f.mismatch_cnt, if_f.level});
    end
    checks++;
    if ({if_b.err_sticky, if_b.match_cnt, if_b.mismatch_cnt, if_b.level} !== 8'b0) begin
      errors++; $display("FAIL reset_b got %b exp 00000000", {if_b.err_sticky, if_b.match_cnt, if_b.mismatch_cnt, if_b.level});
    end
  endtask

  task automatic test_echo();
    do_reset();
    rxd = 8'h11; rx_dv = 1'b1; tick();
    checks++;
    if (if_f.level !== 3'd1) begin errors++; $display("FAIL echo_level_mid got %0d exp 1", if_f.level); end
    rxd = 8'h22; txd = 8'h11; tx_en = 1'b1; tick();
    rxd = 8'h33; txd = 8'h22; tick();
    rx_dv = 1'b0; txd = 8'h33; tick();
    tx_en = 1'b0; tick();
    checks++;
    if (if_f.match_cnt !== 2'd3) begin errors++; $display("FAIL echo_match_f got %0d exp 3", if_f.match_cnt); end
    checks++;
    if (if_b.match_cnt !== 2'd3) begin errors++; $display("FAIL echo_match_b got %0d exp 3", if_b.match_cnt); end
    checks++;
    if ({if_f.err_sticky, if_b.err_sticky, if_f.mismatch_cnt} !== 4'b0) begin
      errors++; $display("FAIL echo_clean got %b exp 0000", {if_f.err_sticky, if_b.err_sticky, if_f.mismatch_cnt});
    end
    checks++;
    if (if_f.level !== 3'd0) begin errors++; $display("FAIL echo_level_end got %0d exp 0", if_f.level); end
  endtask

  task automatic test_mismatch();
    do_reset();
    rxd = 8'hA5; rx_dv = 1'b1; tick();
    rx_dv = 1'b0; txd = 8'h5A; tx_en = 1'b1; tick();
    tx_en = 1'b0;
    checks++;
    if ({if_f.err_mismatch, if_f.err_timing} !== 2'b10) begin
      errors++; $display("FAIL mismatch_pulse got %b exp 10", {if_f.err_mismatch, if_f.err_timing});
    end
    checks++;
    if ({if_f.mismatch_cnt, if_f.match_cnt} !== 4'b0100) begin
      errors++; $display("FAIL mismatch_cnt got %b exp 0100", {if_f.mismatch_cnt, if_f.match_cnt});
    end
    tick();
    checks++;
    if ({if_f.err_mismatch, if_f.err_sticky} !== 2'b01) begin
      errors++; $display("FAIL mismatch_after got %b exp 01", {if_f.err_mismatch, if_f.err_sticky});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    rxd = 8'h01; rx_dv = 1'b1; tick();
    rx_dv = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if (if_b.err_timing !== (k == 5)) begin
        errors++; $display("FAIL timeout_pulse k=%0d got %b exp %b", k, if_b.err_timing, (k == 5));
      end
      checks++;
      if (if_b.level !== ((k < 5) ? 3'd1 : 3'd0)) begin
        errors++; $display("FAIL timeout_level k=%0d got %0d exp %0d", k, if_b.level, (k < 5) ? 1 : 0);
      end
    end
    txd = 8'h01; tx_en = 1'b1; tick();
    tx_en = 1'b0;
    checks++;
    if ({if_b.err_underflow, if_b.err_mismatch, if_b.err_timing} !== 3'b100) begin
      errors++; $display("FAIL timeout_under got %b exp 100", {if_b.err_underflow, if_b.err_mismatch, if_b.err_timing});
    end
    checks++;
    if (if_b.mismatch_cnt !== 2'd2) begin errors++; $display("FAIL timeout_cnt got %0d exp 2", if_b.mismatch_cnt); end
  endtask

  task automatic test_bounded_latency();
    do_reset();
    rxd = 8'h42; rx_dv = 1'b1; tick();
    rx_dv = 1'b0; tick(); tick();
    txd = 8'h42; tx_en = 1'b1; tick();
    tx_en = 1'b0;
    checks++;
    if ({if_b.err_timing, if_b.match_cnt, if_b.mismatch_cnt} !== 5'b00100) begin
      errors++; $display("FAIL bounded_ok got %b exp 00100", {if_b.err_timing, if_b.match_cnt, if_b.mismatch_cnt});
    end
    checks++;
    if ({if_f.err_timing, if_f.err_mismatch, if_f.match_cnt, if_f.mismatch_cnt} !== 6'b100001) begin
      errors++; $display("FAIL fixed_late got %b exp 100001",
        {if_f.err_timing, if_f.err_mismatch, if_f.match_cnt, if_f.mismatch_cnt});
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      rxd = 8'(i); rx_dv = 1'b1; tick();
      checks++;
      if (if_f.err_overflow !== (i == 5)) begin
        errors++; $display("FAIL overflow_pulse i=%0d got %b exp %b", i, if_f.err_overflow, (i == 5));
      end
    end
    checks++;
    if (if_f.level !== 3'd4) begin errors++; $display("FAIL overflow_level got %0d exp 4", if_f.level); end
    rxd = 8'h06; txd = 8'h01; tx_en = 1'b1; tick();
    idle();
    checks++;
    if ({if_f.err_overflow, if_f.err_mismatch, if_f.err_timing} !== 3'b001) begin
      errors++; $display("FAIL full_pushpop_err got %b exp 001", {if_f.err_overflow, if_f.err_mismatch, if_f.err_timing});
    end
    checks++;
    if (if_f.level !== 3'd4) begin errors++; $display("FAIL full_pushpop_level got %0d exp 4", if_f.level); end
  endtask

  task automatic test_saturate_clear();
    do_reset();
    for (int i = 0; i <= 5; i++) begin
      rxd = 8'(i + 1); rx_dv = (i < 5);
      txd = 8'(i);     tx_en = (i > 0);
      tick();
    end
    idle();
    checks++;
    if ({if_f.match_cnt, if_f.mismatch_cnt, if_f.err_sticky} !== 5'b11000) begin
      errors++; $display("FAIL saturate got %b exp 11000", {if_f.match_cnt, if_f.mismatch_cnt, if_f.err_sticky});
    end
    tx_en = 1'b1; tick();
    checks++;
    if ({if_f.err_underflow, if_f.err_sticky, if_f.mismatch_cnt} !== 4'b1101) begin
      errors++; $display("FAIL pre_clear got %b exp 1101", {if_f.err_underflow, if_f.err_sticky, if_f.mismatch_cnt});
    end
    clear = 1'b1; tick();
    idle();
    checks++;
    if ({if_f.err_underflow, if_f.err_sticky, if_f.match_cnt, if_f.mismatch_cnt} !== 6'b100000) begin
      errors++; $display("FAIL clear got %b exp 100000",
        {if_f.err_underflow, if_f.err_sticky, if_f.match_cnt, if_f.mismatch_cnt});
    end
    tick();
    checks++;
    if ({if_f.err_underflow, if_f.err_sticky} !== 2'b00) begin
      errors++; $display("FAIL clear_lost got %b exp 00", {if_f.err_underflow, if_f.err_sticky});
    end
  endtask

  task automatic test_reset_midstream();
    for (int i = 0; i < 3; i++) begin
      rxd = 8'(8'hC0 + i); rx_dv = 1'b1; tick();
    end
    idle();
    checks++;
    if (if_f.level !== 3'd3) begin errors++; $display("FAIL mid_level_pre got %0d exp 3", if_f.level); end
    rst = 1'b1; tick();
    rst = 1'b0;
    checks++;
    if ({if_f.level, if_f.err_sticky, if_f.err_timing} !== 5'b0) begin
      errors++; $display("FAIL mid_reset got %b exp 00000", {if_f.level, if_f.err_sticky, if_f.err_timing});
    end
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if ({if_f.err_sticky, if_b.err_sticky, if_f.mismatch_cnt} !== 4'b0) begin
      errors++; $display("FAIL mid_quiet got %b exp 0000", {if_f.err_sticky, if_b.err_sticky, if_f.mismatch_cnt});
    end
    rxd = 8'h77; rx_dv = 1'b1; tick();
    rxd = 8'h88; txd = 8'h77; tx_en = 1'b1; tick();
    rx_dv = 1'b0; txd = 8'h88; tick();
    idle(); tick();
    checks++;
    if ({if_f.match_cnt, if_f.err_sticky, if_f.level} !== 6'b100000) begin
      errors++; $display("FAIL mid_echo got %b exp 100000", {if_f.match_cnt, if_f.err_sticky, if_f.level});
    end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_echo();
    test_mismatch();
    test_timeout();
    test_bounded_latency();
    test_overflow();
    test_saturate_clear();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
